// File: rtl/dmc_arb_pkg.sv
// Shared types and constants for the dmc front-end arbiter.
// Default widths match the dmc command/data ports.
package dmc_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    localparam logic MEM_A = 1'b0;
    localparam logic MEM_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmc_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the client
// that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/dmc_arbiter.sv
// Two-client arbiter/sequencer driving the single dmc command port.
// One transaction at a time: IDLE -> ISSUE -> [CAPTURE] -> DONE -> IDLE.
module dmc_arbiter
    import dmc_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_sel,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_sel,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_select,
    output logic              write_enable,
    output logic [ADDR_W-1:0] add_ex,
    output logic [DATA_W-1:0] data_ex,
    input  logic [DATA_W-1:0] data_out
);

    arb_state_t state;
    logic       last;
    logic       gnt_id;
    logic       lat_we;

    logic              pick_id;
    logic              pick_valid;
    logic              win_we;
    logic              win_sel;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arb2 u_pick (
        .req       ({r1_req, r0_req}),
        .last      (last),
        .gnt_id    (pick_id),
        .gnt_valid (pick_valid)
    );

    always_comb begin
        win_we    = pick_id ? r1_we    : r0_we;
        win_sel   = pick_id ? r1_sel   : r0_sel;
        win_addr  = pick_id ? r1_addr  : r0_addr;
        win_wdata = pick_id ? r1_wdata : r0_wdata;
    end

    // The dmc command registers double as the latched request fields,
    // so they naturally hold their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            gnt_id       <= 1'b0;
            lat_we       <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
            mem_select   <= MEM_A;
            write_enable <= 1'b0;
            add_ex       <= '0;
            data_ex      <= '0;
        end else begin
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_id       <= pick_id;
                        lat_we       <= win_we;
                        mem_select   <= win_sel;
                        add_ex       <= win_addr;
                        data_ex      <= win_wdata;
                        write_enable <= win_we;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    write_enable <= 1'b0;
                    if (lat_we) begin
                        r0_ack <= ~gnt_id;
                        r1_ack <= gnt_id;
                        state  <= DONE;
                    end else begin
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata  <= data_out;
                    r0_ack <= ~gnt_id;
                    r1_ack <= gnt_id;
                    state  <= DONE;
                end
                DONE: begin
                    last  <= gnt_id;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmc_arbiter.sv
// Directed bench for dmc_arbiter with a dmc memory fixture and a
// transaction-level reference model checked every cycle.
module tb_dmc_arbiter;
    import dmc_arb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          r0_req = 0, r0_we = 0, r0_sel = 0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 0, r1_we = 0, r1_sel = 0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r0_ack, r1_ack, busy, mem_select, write_enable;
    logic [DW-1:0] rdata, data_ex;
    logic [AW-1:0] add_ex;
    logic [DW-1:0] data_out = '0;

    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;

    always #5 clk = ~clk;

    dmc_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_sel(r0_sel), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_sel(r1_sel), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata), .busy(busy),
        .mem_select(mem_select), .write_enable(write_enable), .add_ex(add_ex),
        .data_ex(data_ex), .data_out(data_out)
    );

    // dmc stand-in: synchronous write, registered read
    logic [DW-1:0] fx_mem [2][256] = '{default: '0};
    always @(posedge clk) begin
        if (write_enable) fx_mem[mem_select][add_ex] <= data_ex;
        data_out <= fx_mem[mem_select][add_ex];
    end

    // Reference: a granted transaction occupies m_len cycles after the grant
    // edge (ISSUE, optional CAPTURE, DONE); m_k counts through them.
    int            m_k = 0;
    logic          m_gnt = 0, m_we = 0, m_sel = 0, m_last = 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [DW-1:0] m_mem [2][256] = '{default: '0};

    function automatic int m_len(input logic we);
        return we ? 2 : 3;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_k = 0; m_last = 1; m_rdata = '0; m_sel = 0; m_addr = '0;
            m_wdata = '0; m_we = 0; m_gnt = 0;
        end else if (m_k == 0) begin
            if (r0_req || r1_req) begin
                if (r0_req && r1_req) m_gnt = (m_last == 1'b1) ? 1'b0 : 1'b1;
                else                  m_gnt = r1_req;
                m_we    = m_gnt ? r1_we    : r0_we;
                m_sel   = m_gnt ? r1_sel   : r0_sel;
                m_addr  = m_gnt ? r1_addr  : r0_addr;
                m_wdata = m_gnt ? r1_wdata : r0_wdata;
                m_k = 1;
            end
        end else begin
            if (m_k == 1 && m_we)  m_mem[m_sel][m_addr] = m_wdata;
            if (m_k == 2 && !m_we) m_rdata = m_mem[m_sel][m_addr];
            if (m_k == m_len(m_we)) begin
                m_k = 0;
                m_last = m_gnt;
            end else begin
                m_k++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference, plus event counters
    initial begin
        @(negedge rst_n);
        forever begin
            @(negedge clk);
            chk("cyc_busy",  busy,         m_k != 0);
            chk("cyc_we",    write_enable, m_k == 1 && m_we);
            chk("cyc_ack0",  r0_ack,       m_k != 0 && m_k == m_len(m_we) && !m_gnt);
            chk("cyc_ack1",  r1_ack,       m_k != 0 && m_k == m_len(m_we) && m_gnt);
            chk("cyc_sel",   mem_select,   m_sel);
            chk("cyc_addr",  add_ex,       m_addr);
            chk("cyc_dex",   data_ex,      m_wdata);
            chk("cyc_rdata", rdata,        m_rdata);
            we_cnt   += int'(write_enable);
            ack0_cnt += int'(r0_ack);
            ack1_cnt += int'(r1_ack);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_client(input int c, input logic req, input logic we, input logic sel,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (c == 0) begin
            r0_req = req; r0_we = we; r0_sel = sel; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_sel = sel; r1_addr = addr; r1_wdata = wd;
        end
    endtask

    // Issue one request from an idle arbiter; lat counts edges from
    // the request-sampling edge up to the edge that raised the ack.
    task automatic txn(input int c, input logic we, input logic sel, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
        logic got;
        got = 0; lat = 0; rd = '0;
        set_client(c, 1'b1, we, sel, addr, wd);
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            lat++;
            if ((c == 0 && r0_ack) || (c == 1 && r1_ack)) begin
                got = 1;
                rd = rdata;
            end
        end
        set_client(c, 1'b0, 1'b0, MEM_A, '0, '0);
        chk("txn_timeout", got, 1);
        tick();
    endtask

    task automatic do_reset();
        set_client(0, 0, 0, MEM_A, '0, '0);
        set_client(1, 0, 0, MEM_A, '0, '0);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int            lat, wc, a0, n_ack;
        logic [DW-1:0] rd, w0, w1;
        int            ord [8];

        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_busy",  busy, 0);
        chk("rst_we",    write_enable, 0);
        chk("rst_acks",  {r1_ack, r0_ack}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_cmd",   {mem_select, add_ex, data_ex}, 0);
        rst_n = 1'b1;
        tick();

        // single write then read
        wc = we_cnt;
        txn(0, 1, MEM_A, 8'h02, 8'h0A, lat, rd);
        chk("wr_latency", lat, 2);
        txn(0, 0, MEM_A, 8'h02, 8'h00, lat, rd);
        chk("rd_latency", lat, 3);
        chk("rd_data", rd, 8'h0A);
        chk("we_pulses", we_cnt - wc, 1);

        // memory isolation
        txn(1, 1, MEM_B, 8'h03, 8'h0B, lat, rd);
        txn(0, 1, MEM_A, 8'h03, 8'h33, lat, rd);
        txn(0, 0, MEM_A, 8'h03, 8'h00, lat, rd);
        chk("iso_a", rd, 8'h33);
        txn(1, 0, MEM_B, 8'h03, 8'h00, lat, rd);
        chk("iso_b", rd, 8'h0B);

        // simultaneous requests right after reset
        do_reset();
        set_client(0, 1, 1, MEM_A, 8'h01, 8'h11);
        set_client(1, 1, 1, MEM_A, 8'h01, 8'h22);
        n_ack = 0;
        for (int i = 0; i < 40 && n_ack < 2; i++) begin
            tick();
            if (r0_ack) begin ord[n_ack] = 0; n_ack++; r0_req = 0; end
            if (r1_ack) begin ord[n_ack] = 1; n_ack++; r1_req = 0; end
        end
        r0_req = 0; r1_req = 0;
        tick();
        chk("sim_count", n_ack, 2);
        chk("sim_first", ord[0], 0);
        chk("sim_second", ord[1], 1);
        txn(0, 0, MEM_A, 8'h01, 8'h00, lat, rd);
        chk("sim_final", rd, 8'h22);

        // fairness: both clients request continuously
        do_reset();
        w0 = 8'h40; w1 = 8'h50;
        set_client(0, 1, 1, MEM_A, 8'h10, w0);
        set_client(1, 1, 1, MEM_A, 8'h20, w1);
        n_ack = 0;
        for (int i = 0; i < 100 && n_ack < 8; i++) begin
            tick();
            if (r0_ack) begin ord[n_ack] = 0; n_ack++; w0++; r0_wdata = w0; end
            else if (r1_ack) begin ord[n_ack] = 1; n_ack++; w1++; r1_wdata = w1; end
        end
        r0_req = 0; r1_req = 0;
        tick();
        chk("fair_count", n_ack, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("fair_ord%0d", i), ord[i], i % 2);
        txn(0, 0, MEM_A, 8'h10, 8'h00, lat, rd);
        chk("fair_a10", rd, 8'h43);
        txn(1, 0, MEM_A, 8'h20, 8'h00, lat, rd);
        chk("fair_a20", rd, 8'h53);

        // reset while in CAPTURE
        set_client(0, 1, 0, MEM_A, 8'h02, 8'h00);
        tick(); tick();
        chk("mid_busy", busy, 1);
        a0 = ack0_cnt;
        rst_n = 1'b0;
        r0_req = 0;
        #1;
        chk("mid_we", write_enable, 0);
        chk("mid_rdata", rdata, 0);
        chk("mid_busy0", busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("mid_noack", ack0_cnt - a0, 0);
        txn(0, 0, MEM_A, 8'h02, 8'h00, lat, rd);
        chk("mid_relat", lat, 3);
        chk("mid_redata", rd, 8'h0A);

        // held reads with wdata=FF never write
        wc = we_cnt;
        set_client(0, 1, 0, MEM_A, 8'h01, 8'hFF);
        for (int i = 0; i < 20; i++) tick();
        r0_req = 0;
        tick(); tick();
        chk("ns_we", we_cnt - wc, 0);
        txn(1, 0, MEM_A, 8'h01, 8'h00, lat, rd);
        chk("ns_a1", rd, 8'h22);
        txn(1, 0, MEM_A, 8'h02, 8'h00, lat, rd);
        chk("ns_a2", rd, 8'h0A);
        chk("ns_fx", fx_mem[MEM_B][3], 8'h0B);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
